// File: rtl/keypad_pkg.sv
// Shared constants and the auto-repeat state type for the keypad conditioner.
package keypad_pkg;
  localparam int NKEYS_DEF = 15;
  localparam int KEY_IDX_W = 4;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;
endpackage

// File: rtl/keypad_db_bit.sv
// One key lane: 2-FF synchroniser, tick-sampled history and the accepted level.
module keypad_db_bit #(
  parameter int DB_SAMPLES = 4
)(
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  logic tick,
  input  logic raw,
  output logic lvl,
  output logic lvl_d
);
  logic [1:0]            sync;
  logic [DB_SAMPLES-1:0] hist;

  // synchroniser runs even while disabled so re-enable starts from a settled pin
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) sync <= '0;
    else        sync <= {sync[0], raw};

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst)    hist <= '0;
    else if (!en)  hist <= '0;
    else if (tick) hist <= {hist[DB_SAMPLES-2:0], sync[1]};

  assign lvl_d = (&hist) ? 1'b1 : ((|hist) ? lvl : 1'b0);

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst)   lvl <= 1'b0;
    else if (!en) lvl <= 1'b0;
    else          lvl <= lvl_d;
endmodule

// File: rtl/keypad_conditioner.sv
// Keypad conditioner: per-key debounce, lowest-index priority encode, press strobe.
// Define KEYPAD_REPEAT_EN to add the hold-to-repeat strobe FSM.
module keypad_conditioner
  import keypad_pkg::*;
#(
  parameter int NKEYS      = NKEYS_DEF,
  parameter int TICK_DIV   = 1000,
  parameter int DB_SAMPLES = 4,
  parameter int REP_DELAY  = 64,
  parameter int REP_RATE   = 16
)(
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 en,
  input  logic [NKEYS-1:0]     keys_raw_i,
  output logic [NKEYS-1:0]     keys_o,
  output logic                 key_valid_o,
  output logic [KEY_IDX_W-1:0] key_idx_o,
  output logic                 press_strobe_o
);
  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0]        pcnt;
  logic                 tick;
  logic [NKEYS-1:0]     keys_d;
  logic [KEY_IDX_W-1:0] idx_d;
  logic                 valid_d, press_d, press_q;

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst)    pcnt <= '0;
    else if (!en)  pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + PW'(1);

  assign tick = en && (pcnt == PW'(TICK_DIV-1));

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    keypad_db_bit #(.DB_SAMPLES(DB_SAMPLES)) u_bit (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (en),
      .tick  (tick),
      .raw   (keys_raw_i[k]),
      .lvl   (keys_o[k]),
      .lvl_d (keys_d[k])
    );
  end

  always_comb begin
    idx_d = '0;
    for (int k = NKEYS-1; k >= 0; k--)
      if (keys_d[k]) idx_d = KEY_IDX_W'(k);
  end

  assign valid_d = |keys_d;
  assign press_d = |(keys_d & ~keys_o);

  // index/valid/strobe register alongside keys_o inside the lanes
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      key_valid_o <= 1'b0;
      key_idx_o   <= '0;
      press_q     <= 1'b0;
    end else if (!en) begin
      key_valid_o <= 1'b0;
      key_idx_o   <= '0;
      press_q     <= 1'b0;
    end else begin
      key_valid_o <= valid_d;
      key_idx_o   <= idx_d;
      press_q     <= press_d;
    end

`ifdef KEYPAD_REPEAT_EN
  localparam int CW = $clog2(REP_DELAY+1);

  rep_state_t    state;
  logic [CW-1:0] tcnt;
  logic          tick_q, rep_stb;

  // tick_q lines the tick count up with the cycle keys_d moves, so repeats land
  // a whole number of ticks after the press strobe
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state   <= IDLE;
      tcnt    <= '0;
      tick_q  <= 1'b0;
      rep_stb <= 1'b0;
    end else if (!en) begin
      state   <= IDLE;
      tcnt    <= '0;
      tick_q  <= 1'b0;
      rep_stb <= 1'b0;
    end else begin
      tick_q  <= tick;
      rep_stb <= 1'b0;
      if (!valid_d) begin
        state <= IDLE;
        tcnt  <= '0;
      end else if (press_d || (idx_d != key_idx_o)) begin
        state <= DELAY;
        tcnt  <= '0;
      end else if (tick_q) begin
        case (state)
          DELAY:
            if (tcnt == CW'(REP_DELAY-1)) begin
              rep_stb <= 1'b1;
              state   <= REPEAT;
              tcnt    <= '0;
            end else tcnt <= tcnt + CW'(1);
          REPEAT:
            if (tcnt == CW'(REP_RATE-1)) begin
              rep_stb <= 1'b1;
              tcnt    <= '0;
            end else tcnt <= tcnt + CW'(1);
          default: ;
        endcase
      end
    end

  assign press_strobe_o = press_q | rep_stb;
`else
  assign press_strobe_o = press_q;
`endif
endmodule
